uart_tx_buffered: RTL and testbench



---
 rtl/uart_pkg.sv | 16 +
 rtl/sync_fifo.sv | 70 +++++++
 rtl/uart_tx_buffered.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and baud divisors for the 27 MHz board clock.
package uart_pkg;

    localparam int unsigned CLK_HZ      = 27_000_000;
    localparam int unsigned CLKS_115200 = CLK_HZ / 115_200;  // 234
    localparam int unsigned CLKS_9600   = CLK_HZ / 9_600;    // 2812

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data; push is ignored when full, pop when empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        // Power-of-two depth lets the pointers wrap naturally.
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: valid/ready byte sink, FIFO queue, 8-N-1 serialiser with optional parity and 1/2 stop bits.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_115200,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic             stop_idx_q, stop_idx_d;
    logic             tx_q, tx_d;

    logic       fifo_pop, fifo_full, fifo_empty;
    logic [7:0] fifo_rdata;
    logic       bit_done, start_frame;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign in_ready = !fifo_full;
    assign uart_tx  = tx_q;
    assign busy     = (state_q != IDLE) || !fifo_empty;
    assign bit_done = (cnt_q == CNT_LAST);

    // tx_d always carries the level of the bit about to start, so the line is a pure flop.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        stop_idx_d  = stop_idx_q;
        tx_d        = tx_q;
        fifo_pop    = 1'b0;
        start_frame = 1'b0;

        if (state_q != IDLE) begin
            cnt_d = bit_done ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                tx_d  = 1'b1;
                cnt_d = '0;
                if (!fifo_empty) begin
                    start_frame = 1'b1;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_idx_q == 3'd7) begin
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d    = STOP;
                            stop_idx_d = 1'b0;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_d    = STOP;
                    stop_idx_d = 1'b0;
                    tx_d       = 1'b1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (stop_idx_q == STOP_LAST) begin
                        if (!fifo_empty) begin
                            start_frame = 1'b1;
                        end else begin
                            state_d = IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        if (start_frame) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            parity_d = (^fifo_rdata) ^ (PARITY_ODD != 0);
            state_d  = START;
            cnt_d    = '0;
            tx_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            stop_idx_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            stop_idx_q <= stop_idx_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: three instances (8N1, even parity + 2 stop, odd parity) at 4 clocks per bit.
module tb_uart_tx_buffered;

    logic       clk;
    logic       rst_n;
    logic       iv     [3];
    logic [7:0] id     [3];
    logic       rdy_w  [3];
    logic       tx_w   [3];
    logic       busy_w [3];
    logic [4:0] cnt_w  [3];

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc   = 0;

    typedef struct {
        int unsigned sel;
        logic [7:0]  data;
        int unsigned nbits;
        logic [11:0] bits;   // bit i = i-th level on the line, start bit first
    } vec_t;

    typedef struct {
        logic [7:0]  data;
        int unsigned start;
        logic        frame_ok;
    } rx_t;

    rx_t rxq[$];

    uart_tx_buffered #(
        .CLKS_PER_BIT (4), .FIFO_DEPTH (16), .PARITY_EN (0), .PARITY_ODD (0), .STOP_BITS (1)
    ) dut0 (
        .clk (clk), .rst_n (rst_n), .in_data (id[0]), .in_valid (iv[0]), .in_ready (rdy_w[0]),
        .uart_tx (tx_w[0]), .busy (busy_w[0]), .fifo_count (cnt_w[0])
    );

    uart_tx_buffered #(
        .CLKS_PER_BIT (4), .FIFO_DEPTH (16), .PARITY_EN (1), .PARITY_ODD (0), .STOP_BITS (2)
    ) dut1 (
        .clk (clk), .rst_n (rst_n), .in_data (id[1]), .in_valid (iv[1]), .in_ready (rdy_w[1]),
        .uart_tx (tx_w[1]), .busy (busy_w[1]), .fifo_count (cnt_w[1])
    );

    uart_tx_buffered #(
        .CLKS_PER_BIT (4), .FIFO_DEPTH (16), .PARITY_EN (1), .PARITY_ODD (1), .STOP_BITS (1)
    ) dut2 (
        .clk (clk), .rst_n (rst_n), .in_data (id[2]), .in_valid (iv[2]), .in_ready (rdy_w[2]),
        .uart_tx (tx_w[2]), .busy (busy_w[2]), .fifo_count (cnt_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Decodes 8N1 frames on dut0's line, sampling mid-bit, with the start-edge cycle recorded.
    initial begin : mon
        int unsigned st;
        logic        fok;
        logic [7:0]  d;
        forever begin
            @(posedge clk); #1;
            if (rst_n && !tx_w[0]) begin
                st  = cyc;
                fok = 1'b1;
                d   = '0;
                repeat (2) @(posedge clk); #1;
                if (tx_w[0] !== 1'b0) fok = 1'b0;
                for (int b = 0; b < 8; b++) begin
                    repeat (4) @(posedge clk); #1;
                    d[b] = tx_w[0];
                end
                repeat (4) @(posedge clk); #1;
                if (tx_w[0] !== 1'b1) fok = 1'b0;
                rxq.push_back('{d, st, fok});
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got %0d compared, expected run to end", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t        vecs [8];
        int unsigned s;
        int unsigned k;
        int unsigned bound;
        int unsigned acc [18];
        logic [7:0]  b2b [3];
        logic        rdy;
        logic        ok;

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0;
            id[i] = '0;
        end
        for (int i = 0; i < 18; i++) acc[i] = 0;

        repeat (3) @(posedge clk); #1;
        check("rst_tx",    tx_w[0],   1);
        check("rst_busy",  busy_w[0], 0);
        check("rst_count", cnt_w[0],  0);
        check("rst_ready", rdy_w[0],  1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_tx",   tx_w[1],   1);
        check("post_rst_busy", busy_w[2], 0);

        vecs[0] = '{0, 8'hA5, 10, {2'b00, 1'b1, 8'hA5, 1'b0}};
        vecs[1] = '{0, 8'h00, 10, {2'b00, 1'b1, 8'h00, 1'b0}};
        vecs[2] = '{0, 8'hFF, 10, {2'b00, 1'b1, 8'hFF, 1'b0}};
        vecs[3] = '{1, 8'h07, 12, {1'b1, 1'b1, 1'b1, 8'h07, 1'b0}};
        vecs[4] = '{1, 8'h00, 12, {1'b1, 1'b1, 1'b0, 8'h00, 1'b0}};
        vecs[5] = '{1, 8'h80, 12, {1'b1, 1'b1, 1'b1, 8'h80, 1'b0}};
        vecs[6] = '{2, 8'h07, 11, {1'b0, 1'b1, 1'b0, 8'h07, 1'b0}};
        vecs[7] = '{2, 8'hFF, 11, {1'b0, 1'b1, 1'b1, 8'hFF, 1'b0}};

        for (int i = 0; i < 8; i++) begin
            s = vecs[i].sel;
            iv[s] = 1'b1;
            id[s] = vecs[i].data;
            @(posedge clk); #1;
            check($sformatf("v%0d_count_after_push", i), cnt_w[s], 1);
            check($sformatf("v%0d_tx_before_start", i), tx_w[s], 1);
            iv[s] = 1'b0;
            @(posedge clk); #1;
            check($sformatf("v%0d_start_edge", i), tx_w[s], 0);
            check($sformatf("v%0d_count_after_pop", i), cnt_w[s], 0);
            for (int b = 0; b < 12; b++) begin
                if (b < int'(vecs[i].nbits)) begin
                    repeat (2) @(posedge clk); #1;
                    check($sformatf("v%0d_bit%0d", i, b), tx_w[s], vecs[i].bits[b]);
                    if (b == int'(vecs[i].nbits) - 1)
                        check($sformatf("v%0d_busy_last_bit", i), busy_w[s], 1);
                    repeat (2) @(posedge clk);
                end
            end
            #1;
            check($sformatf("v%0d_busy_after_frame", i), busy_w[s], 0);
            check($sformatf("v%0d_idle_line", i), tx_w[s], 1);
        end

        // Back-to-back frames with zero idle gap.
        rxq.delete();
        b2b[0] = 8'h4D; b2b[1] = 8'h34; b2b[2] = 8'h6E;
        iv[0] = 1'b1; id[0] = b2b[0];
        @(posedge clk); #1;
        acc[0] = cyc;
        id[0] = b2b[1];
        @(posedge clk); #1;
        id[0] = b2b[2];
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (130) @(posedge clk); #1;
        check("b2b_frames", rxq.size(), 3);
        if (rxq.size() == 3) begin
            check("b2b_first_latency", rxq[0].start, acc[0] + 1);
            check("b2b_gap_1", rxq[1].start - rxq[0].start, 40);
            check("b2b_gap_2", rxq[2].start - rxq[1].start, 40);
            for (int j = 0; j < 3; j++) begin
                check($sformatf("b2b_byte%0d", j), rxq[j].data, b2b[j]);
                check($sformatf("b2b_framing%0d", j), rxq[j].frame_ok, 1);
            end
        end
        check("b2b_idle", busy_w[0], 0);

        // FIFO full: hold in_valid through 18 bytes while the first frame occupies the line.
        rxq.delete();
        k = 0; bound = 0;
        iv[0] = 1'b1; id[0] = 8'h10;
        while (k < 18 && bound < 200) begin
            rdy = rdy_w[0];
            @(posedge clk); #1;
            bound++;
            if (rdy) begin
                acc[k] = cyc;
                k++;
                id[0] = 8'(8'h10 + k);
                if (k == 17) begin
                    check("full_count", cnt_w[0], 16);
                    check("full_ready_low", rdy_w[0], 0);
                end
            end
        end
        iv[0] = 1'b0;
        check("full_all_accepted", k, 18);
        check("full_16th_timing", acc[16] - acc[0], 16);
        check("full_17th_after_pop", acc[17] - acc[0], 42);
        repeat (740) @(posedge clk); #1;
        check("full_frames", rxq.size(), 18);
        for (int j = 0; j < 18; j++) begin
            if (j < rxq.size()) begin
                check($sformatf("full_byte%0d", j), rxq[j].data, 8'(8'h10 + j));
                check($sformatf("full_framing%0d", j), rxq[j].frame_ok, 1);
            end
        end

        // Push on the same edge as a pop with fifo_count = DEPTH-1.
        rxq.delete();
        iv[0] = 1'b1;
        for (int j = 0; j < 16; j++) begin
            id[0] = 8'(8'h40 + j);
            @(posedge clk); #1;
        end
        iv[0] = 1'b0;
        check("sim_fill_count", cnt_w[0], 15);
        repeat (25) @(posedge clk); #1;
        check("sim_pre_pop_count", cnt_w[0], 15);
        iv[0] = 1'b1; id[0] = 8'h50;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        check("sim_post_count", cnt_w[0], 15);
        check("sim_post_ready", rdy_w[0], 1);
        repeat (660) @(posedge clk); #1;
        check("sim_frames", rxq.size(), 17);
        for (int j = 0; j < 17; j++) begin
            if (j < rxq.size())
                check($sformatf("sim_byte%0d", j), rxq[j].data, 8'(8'h40 + j));
        end

        // Reset during data bit 3 with five bytes queued.
        iv[0] = 1'b1; id[0] = 8'hF7;
        @(posedge clk); #1;
        for (int j = 1; j <= 5; j++) begin
            id[0] = 8'(j);
            @(posedge clk); #1;
        end
        iv[0] = 1'b0;
        repeat (13) @(posedge clk); #1;
        check("rstmid_bit3_low", tx_w[0], 0);
        check("rstmid_queued", cnt_w[0], 5);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_tx_high", tx_w[0], 1);
        check("rstmid_count", cnt_w[0], 0);
        check("rstmid_busy", busy_w[0], 0);
        check("rstmid_ready", rdy_w[0], 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ok = 1'b1;
        repeat (60) begin
            @(posedge clk); #1;
            if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || cnt_w[0] !== 5'd0) ok = 1'b0;
        end
        check("rstmid_silent_after", ok, 1);
        rxq.delete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
